// File: rtl/mem_bus_arbiter.sv
// Arbiter that shares one single-port bus between instruction fetch and data access.
// Data has priority over fetch. Every transaction goes back through IDLE before the next one starts.
//
// state  | meaning
// IDLE   | no bus cycle; accepts a data request first, otherwise a fetch request
// D_BUSY | data bus cycle in progress, waiting for ack
// I_BUSY | fetch bus cycle in progress, waiting for ack
// D_HOLD | data result held in mem_rdata while stall[4] is high
// I_HOLD | fetch result held in if_rdata while stall[1] is high
module mem_bus_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_stallreq,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_stallreq,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_BUSY = 3'd1,
      I_BUSY = 3'd2,
      D_HOLD = 3'd3,
      I_HOLD = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic        flush_pend, flush_pend_nxt;
   logic        cyc_nxt, stb_nxt, we_nxt;
   logic [3:0]  sel_nxt;
   logic [31:0] addr_nxt, data_nxt;
   logic [31:0] if_rdata_nxt, mem_rdata_nxt;

   // Only the fetch and data stage stall bits matter here.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

   assign mem_stallreq = mem_req && (state != D_HOLD) && !flush;
   assign if_stallreq  = if_req  && (state != I_HOLD) && !flush;

   always_comb begin
      state_nxt      = state;
      flush_pend_nxt = flush_pend;
      cyc_nxt        = bus_cyc_o;
      stb_nxt        = bus_stb_o;
      we_nxt         = bus_we_o;
      sel_nxt        = bus_sel_o;
      addr_nxt       = bus_addr_o;
      data_nxt       = bus_data_o;
      if_rdata_nxt   = if_rdata;
      mem_rdata_nxt  = mem_rdata;
      case (state)
         IDLE: begin
            flush_pend_nxt = 1'b0;
            if (!flush) begin
               if (mem_req) begin
                  cyc_nxt   = 1'b1;
                  stb_nxt   = 1'b1;
                  we_nxt    = mem_we;
                  sel_nxt   = mem_sel;
                  addr_nxt  = mem_addr;
                  data_nxt  = mem_wdata;
                  state_nxt = D_BUSY;
               end else if (if_req) begin
                  cyc_nxt   = 1'b1;
                  stb_nxt   = 1'b1;
                  we_nxt    = 1'b0;
                  sel_nxt   = 4'b1111;
                  addr_nxt  = if_addr;
                  data_nxt  = 32'h0;
                  state_nxt = I_BUSY;
               end
            end
         end
         D_BUSY, I_BUSY: begin
            if (bus_ack_i) begin
               cyc_nxt = 1'b0;
               stb_nxt = 1'b0;
               we_nxt  = 1'b0;
               // A flush arriving together with the ack also discards the result.
               if (flush_pend || flush) begin
                  flush_pend_nxt = 1'b0;
                  state_nxt      = IDLE;
               end else if (state == D_BUSY) begin
                  mem_rdata_nxt = bus_data_i;
                  state_nxt     = D_HOLD;
               end else begin
                  if_rdata_nxt = bus_data_i;
                  state_nxt    = I_HOLD;
               end
            end else if (flush) begin
               flush_pend_nxt = 1'b1;
            end
         end
         D_HOLD: begin
            if (!stall[4] || flush) state_nxt = IDLE;
         end
         I_HOLD: begin
            if (!stall[1] || flush) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
         bus_cyc_o  <= 1'b0;
         bus_stb_o  <= 1'b0;
         bus_we_o   <= 1'b0;
         bus_sel_o  <= 4'h0;
         bus_addr_o <= 32'h0;
         bus_data_o <= 32'h0;
         if_rdata   <= 32'h0;
         mem_rdata  <= 32'h0;
      end else begin
         state      <= state_nxt;
         flush_pend <= flush_pend_nxt;
         bus_cyc_o  <= cyc_nxt;
         bus_stb_o  <= stb_nxt;
         bus_we_o   <= we_nxt;
         bus_sel_o  <= sel_nxt;
         bus_addr_o <= addr_nxt;
         bus_data_o <= data_nxt;
         if_rdata   <= if_rdata_nxt;
         mem_rdata  <= mem_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected bus cycles go into a scoreboard queue,
// a monitor pops one per observed cycle start; result and stall outputs are checked inline.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_stallreq;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_stallreq;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_txn_t;

   bus_txn_t exp_q[$];
   int       vectors = 0;
   int       miscompares = 0;
   logic     prev_cyc = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: each new bus cycle must match the oldest expected transaction.
   always @(negedge clk) begin
      if (bus_cyc_o && !prev_cyc) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_cycle: addr %h with empty scoreboard", bus_addr_o);
         end else begin
            bus_txn_t e;
            e = exp_q.pop_front();
            if (!bus_stb_o || bus_we_o !== e.we || bus_sel_o !== e.sel ||
                bus_addr_o !== e.addr || (e.we && bus_data_o !== e.data)) begin
               miscompares++;
               $display("FAIL bus_cycle: got stb=%b we=%b sel=%h addr=%h data=%h expected we=%b sel=%h addr=%h data=%h",
                        bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
                        e.we, e.sel, e.addr, e.data);
            end
         end
      end
      prev_cyc <= bus_cyc_o;
   end

   initial begin
      rst = 1'b0; stall = 6'h0; flush = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
      bus_data_i = 32'h0; bus_ack_i = 1'b0;
      step(); step();
      @(negedge clk);
      chk("rst_cyc", {31'h0, bus_cyc_o}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      rst = 1'b1;
      step();

      // Fetch read, ack two cycles after the cycle starts.
      if_req = 1'b1; if_addr = 32'h0000_0100;
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h0000_0100, data: 32'h0});
      @(negedge clk);
      chk("fetch_stallreq_idle", {31'h0, if_stallreq}, 32'h1);
      step();
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'h3C01_0001;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      chk("fetch_rdata", if_rdata, 32'h3C01_0001);
      chk("fetch_stallreq_hold", {31'h0, if_stallreq}, 32'h0);
      chk("fetch_cyc_drop", {31'h0, bus_cyc_o}, 32'h0);
      if_req = 1'b0;
      step();

      // Collision: data wins, then an idle cycle, then the fetch.
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
      if_req = 1'b1; if_addr = 32'h0000_0200;
      exp_q.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h80, data: 32'hDEAD_BEEF});
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h0000_0200, data: 32'h0});
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'h1111_2222;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      chk("coll_mem_rdata", mem_rdata, 32'h1111_2222);
      chk("coll_mem_stallreq_hold", {31'h0, mem_stallreq}, 32'h0);
      mem_req = 1'b0; mem_we = 1'b0;
      step();
      @(negedge clk);
      chk("coll_idle_gap", {31'h0, bus_cyc_o}, 32'h0);
      chk("coll_if_stallreq", {31'h0, if_stallreq}, 32'h1);
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'h2222_3333;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      chk("coll_if_rdata", if_rdata, 32'h2222_3333);
      if_req = 1'b0;
      step();

      // Flush during a data cycle: cycle completes, result discarded, back to IDLE.
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_sel = 4'hF;
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h40, data: 32'h0});
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_mem_stallreq", {31'h0, mem_stallreq}, 32'h0);
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_cyc_kept", {31'h0, bus_cyc_o}, 32'h1);
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'hBAD0_BAD0;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      chk("flush_rdata_kept", mem_rdata, 32'h1111_2222);
      chk("flush_to_idle", {31'h0, mem_stallreq}, 32'h1);
      chk("flush_cyc_drop", {31'h0, bus_cyc_o}, 32'h0);
      mem_req = 1'b0;
      step();

      // Hold: stall[4] keeps D_HOLD for three cycles; acks there are ignored.
      stall = 6'b010000;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hC0; mem_sel = 4'hF;
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'hC0, data: 32'h0});
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_F00D;
      step();
      bus_data_i = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_stallreq", {31'h0, mem_stallreq}, 32'h0);
         chk("hold_rdata", mem_rdata, 32'hCAFE_F00D);
         chk("hold_cyc", {31'h0, bus_cyc_o}, 32'h0);
         if (i < 2) step();
      end
      bus_ack_i = 1'b0; stall = 6'h0; mem_req = 1'b0;
      step();
      mem_req = 1'b1;
      @(negedge clk);
      chk("hold_released", {31'h0, mem_stallreq}, 32'h1);
      chk("hold_rdata_after", mem_rdata, 32'hCAFE_F00D);
      mem_req = 1'b0;
      step();

      // Reset in the middle of a fetch cycle, then a late ack.
      if_req = 1'b1; if_addr = 32'h0000_0300;
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h0000_0300, data: 32'h0});
      step();
      rst = 1'b0; if_req = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy_cyc", {31'h0, bus_cyc_o}, 32'h0);
      chk("rst_busy_stb", {31'h0, bus_stb_o}, 32'h0);
      chk("rst_busy_if_rdata", if_rdata, 32'h0);
      chk("rst_busy_mem_rdata", mem_rdata, 32'h0);
      bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_FFFF;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      chk("late_ack_if_rdata", if_rdata, 32'h0);
      chk("late_ack_cyc", {31'h0, bus_cyc_o}, 32'h0);
      step(); step();

      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have ports: clk in 1 (system clock); rst in 1 (reset, synchronous, active-low: 0 = reset).
REQ-002 SHALL have pipeline-control ports: stall in 6 (ctrl stall vector); flush in 1 (pipeline flush).
REQ-003 SHALL have fetch-side ports: if_req in 1; if_addr in 32; if_rdata out 32; if_stallreq out 1.
REQ-004 SHALL have data-side ports: mem_req in 1; mem_we in 1; mem_sel in 4; mem_addr in 32; mem_wdata in 32; mem_rdata out 32; mem_stallreq out 1.
REQ-005 SHALL have bus-master ports: bus_cyc_o out 1; bus_stb_o out 1; bus_we_o out 1; bus_sel_o out 4; bus_addr_o out 32; bus_data_o out 32; bus_data_i in 32; bus_ack_i in 1.
REQ-006 Clock: one clock, clk. Reset: synchronous, active-low, port rst.

Function
REQ-007 SHALL share one single-port bus between fetch (IF) and data (MEM) requesters.
REQ-008 SHALL implement FSM states IDLE, D_BUSY, I_BUSY, D_HOLD, I_HOLD; all bus_* outputs and if_rdata/mem_rdata registered.
REQ-009 IDLE, flush=0, mem_req=1: latch mem_we/sel/addr/wdata onto bus_*; cyc=stb=1; go D_BUSY at next edge.
REQ-010 IDLE, flush=0, mem_req=0, if_req=1: drive if_addr; we=0, sel=4'b1111, cyc=stb=1; go I_BUSY.
REQ-011 Data SHALL have strict priority over fetch when both are requested in IDLE.
REQ-012 D_BUSY/I_BUSY: bus outputs held stable until bus_ack_i=1; no new request accepted.
REQ-013 On bus_ack_i=1 in a BUSY state: cyc=stb=we=0 at next edge; bus_data_i captured into mem_rdata (D) or if_rdata (I).
REQ-014 After ack: go D_HOLD/I_HOLD if no flush was seen during the transaction, else IDLE with result discarded (rdata unchanged).
REQ-015 flush=1 in any BUSY state SHALL NOT abort the bus cycle; it SHALL be recorded in a pending-flush flag, cleared on return to IDLE.
REQ-016 D_HOLD: return to IDLE when stall[4]=0 or flush=1, else remain; mem_rdata held.
REQ-017 I_HOLD: return to IDLE when stall[1]=0 or flush=1, else remain; if_rdata held.
REQ-018 mem_stallreq = mem_req AND state≠D_HOLD AND flush=0 (combinational).
REQ-019 if_stallreq = if_req AND state≠I_HOLD AND flush=0 (combinational).
REQ-020 Each accepted request SHALL produce exactly one bus cycle; no back-to-back cycle without passing through IDLE (minimum 1 idle cycle between bus cycles).
REQ-021 Latency: request sampled at edge N → cyc=1 from N; ack at edge N+k → HOLD and rdata valid from edge N+k.
REQ-022 bus_ack_i while state IDLE or HOLD SHALL be ignored.

Reset
REQ-023 rst=0 at a clock edge: state=IDLE; pending-flush=0; all bus_* outputs, if_rdata, mem_rdata = 0.
REQ-024 Reset mid-transaction SHALL drop cyc/stb at that edge without waiting for ack.

Verification
REQ-025 Fetch read: if_req=1, if_addr=0x00000100, ack after 2 cycles with data 0x3C010001 → one bus cycle, we=0, sel=1111, if_rdata=0x3C010001, if_stallreq falls in I_HOLD.
REQ-026 Collision: mem_req=1 (we=1, addr=0x80, wdata=0xDEADBEEF, sel=0011) and if_req=1 together in IDLE → data cycle first, then idle cycle, then fetch cycle.
REQ-027 Flush in D_BUSY: flush pulse before ack → cycle completes, FSM returns IDLE not D_HOLD, mem_rdata unchanged.
REQ-028 Hold: data ack while stall[4]=1 for 3 cycles → remains D_HOLD 3 cycles, mem_stallreq=0, mem_rdata stable; IDLE after stall[4]=0.
REQ-029 Reset in I_BUSY: rst=0 one edge → cyc=stb=0, state IDLE, rdata outputs 0; late ack ignored.
